// File: rtl/seven_seg_pkg.sv
// Shared 7-segment glyph constants and types for the display encoder/capture pair.
// Pattern bit order is {g,f,e,d,c,b,a}, segment a in bit 0, active-high.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

  typedef enum logic [1:0] {
    S_ACQ  = 2'd0,
    S_PUB  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // A decoded digit; err marks a pattern that is not a legal hex glyph.
  typedef struct packed {
    logic       err;
    logic [3:0] nibble;
  } cand_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational 7-segment pattern to hex nibble; illegal glyphs give nibble 0 with err set.
// Zero latency, no flow control.
module seven_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       err,
  output logic [3:0] nibble
);

  always_comb begin
    err    = 1'b0;
    nibble = 4'h0;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Recovers the hex word on a scanned 7-seg bus; dout_valid pulses 3 edges after the last stabilising sample.
// No backpressure: a sample is taken whenever dig_en is one-hot, and outputs are single-cycle pulses.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int STABLE_CNT     = 3,
  parameter int SEG_ACTIVE_LOW = 0
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   dout,
  output logic [DIGITS-1:0]     dig_err,
  output logic                  dout_valid,
  output logic                  bus_err
);

  localparam logic [3:0] STABLE_LIM = 4'(STABLE_CNT);

  logic [6:0]          seg_d, seg_q;
  logic [DIGITS-1:0]   en_d, en_q;
  logic                one_hot, multi_hot;
  logic                dec_err;
  logic [3:0]          dec_nibble;
  cand_t               dec;

  cand_t               cand_d [DIGITS];
  cand_t               cand_q [DIGITS];
  logic [3:0]          cnt_d  [DIGITS];
  logic [3:0]          cnt_q  [DIGITS];

  logic                all_stable, differs;
  logic [4*DIGITS-1:0] cand_word;
  logic [DIGITS-1:0]   cand_err;

  state_t              state_d, state_q;
  logic [4*DIGITS-1:0] dout_d, dout_q;
  logic [DIGITS-1:0]   dig_err_d, dig_err_q;
  logic                dout_valid_d, dout_valid_q;
  logic                published_d, published_q;
  logic                bus_err_d, bus_err_q;

  // Input stage
  always_comb begin
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_in : seg_in;
    en_d  = dig_en;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= '0;
      en_q  <= '0;
    end else begin
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  seven_seg_decode u_decode (
    .seg    (seg_q),
    .err    (dec_err),
    .nibble (dec_nibble)
  );

  always_comb begin
    dec.err    = dec_err;
    dec.nibble = dec_nibble;
    one_hot    = $onehot(en_q);
    multi_hot  = (en_q != '0) && !one_hot;
    bus_err_d  = multi_hot;
  end

  // Per-digit stability filter; a multi-hot strobe leaves every digit untouched.
  always_comb begin
    for (int k = 0; k < DIGITS; k++) begin
      cand_d[k] = cand_q[k];
      cnt_d[k]  = cnt_q[k];
      if (one_hot && en_q[k]) begin
        if (dec == cand_q[k]) begin
          if (cnt_q[k] != STABLE_LIM) begin
            cnt_d[k] = cnt_q[k] + 4'd1;
          end
        end else begin
          cand_d[k] = dec;
          cnt_d[k]  = 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DIGITS; k++) begin
        cand_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      bus_err_q <= 1'b0;
    end else begin
      for (int k = 0; k < DIGITS; k++) begin
        cand_q[k] <= cand_d[k];
        cnt_q[k]  <= cnt_d[k];
      end
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    all_stable = 1'b1;
    cand_word  = '0;
    cand_err   = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (cnt_q[k] != STABLE_LIM) begin
        all_stable = 1'b0;
      end
      cand_word[4*k +: 4] = cand_q[k].nibble;
      cand_err[k]         = cand_q[k].err;
    end
    differs = (cand_word != dout_q) || (cand_err != dig_err_q);
  end

  // Publish FSM; the first complete frame after reset always publishes, even if it matches dout.
  always_comb begin
    state_d      = state_q;
    dout_d       = dout_q;
    dig_err_d    = dig_err_q;
    published_d  = published_q;
    dout_valid_d = 1'b0;
    case (state_q)
      S_ACQ: begin
        if (all_stable) begin
          if (!published_q || differs) begin
            state_d      = S_PUB;
            dout_d       = cand_word;
            dig_err_d    = cand_err;
            published_d  = 1'b1;
            dout_valid_d = 1'b1;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_PUB: begin
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!all_stable) begin
          state_d = S_ACQ;
        end
      end
      default: begin
        state_d = S_ACQ;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_ACQ;
      dout_q       <= '0;
      dig_err_q    <= '0;
      dout_valid_q <= 1'b0;
      published_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      dout_q       <= dout_d;
      dig_err_q    <= dig_err_d;
      dout_valid_q <= dout_valid_d;
      published_q  <= published_d;
    end
  end

  assign dout       = dout_q;
  assign dig_err    = dig_err_q;
  assign dout_valid = dout_valid_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed scan sequences for seven_seg_capture; expected publishes are queued and checked by a monitor.
module tb_seven_seg_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_in;
  logic [3:0]  dig_en;
  logic [15:0] dout;
  logic [3:0]  dig_err;
  logic        dout_valid;
  logic        bus_err;

  int          total   = 0;
  int          bad     = 0;
  int          bus_cnt = 0;
  int          bus_base;
  logic        prev_valid = 1'b0;
  logic [19:0] exp_q [$];
  logic [19:0] exp_item;

  always #5 clk = ~clk;

  seven_seg_capture #(
    .DIGITS         (4),
    .STABLE_CNT     (3),
    .SEG_ACTIVE_LOW (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_en     (dig_en),
    .dout       (dout),
    .dig_err    (dig_err),
    .dout_valid (dout_valid),
    .bus_err    (bus_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every publish must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got dout=%h dig_err=%b expected no pulse", dout, dig_err);
        end else begin
          exp_item = exp_q.pop_front();
          check("pulse_value", {12'h0, dout, dig_err}, {12'h0, exp_item});
        end
        check("no_back_to_back", {31'h0, prev_valid}, 32'h0);
      end
      if (bus_err === 1'b1) bus_cnt++;
    end
    prev_valid = dout_valid;
  end

  task automatic drive(input logic [6:0] s, input logic [3:0] en);
    @(posedge clk);
    #1;
    seg_in = s;
    dig_en = en;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(7'h00, 4'b0000);
  endtask

  // pats = {d3, d2, d1, d0}, scanned round-robin d0..d3
  task automatic scan(input logic [27:0] pats, input int rounds);
    for (int r = 0; r < rounds; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(pats[7*k +: 7], 4'(1 << k));
      end
    end
    idle(1);
  endtask

  initial begin
    rst_n  = 1'b0;
    seg_in = 7'h00;
    dig_en = 4'b0000;
    #12;
    check("reset_dout", {16'h0, dout}, 32'h0);
    check("reset_dig_err", {28'h0, dig_err}, 32'h0);
    check("reset_dout_valid", {31'h0, dout_valid}, 32'h0);
    check("reset_bus_err", {31'h0, bus_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // F, A, 2, 1 -> 0x12AF
    exp_q.push_back({16'h12AF, 4'b0000});
    scan({7'h06, 7'h5B, 7'h77, 7'h71}, 3);
    idle(6);
    check("first_publish_seen", exp_q.size(), 32'd0);
    scan({7'h06, 7'h5B, 7'h77, 7'h71}, 2);
    idle(6);
    check("steady_dout", {16'h0, dout}, 32'h12AF);

    // d1 -> b
    exp_q.push_back({16'h12BF, 4'b0000});
    scan({7'h06, 7'h5B, 7'h7C, 7'h71}, 3);
    idle(6);
    check("change_publish_seen", exp_q.size(), 32'd0);

    // d2 glitches blank for one scan, then returns: no publish
    scan({7'h06, 7'h00, 7'h7C, 7'h71}, 1);
    scan({7'h06, 7'h5B, 7'h7C, 7'h71}, 3);
    idle(6);
    check("glitch_dout", {16'h0, dout}, 32'h12BF);
    check("glitch_dig_err", {28'h0, dig_err}, 32'h0);

    // d3 illegal glyph
    exp_q.push_back({16'h02BF, 4'b1000});
    scan({7'h49, 7'h5B, 7'h7C, 7'h71}, 3);
    idle(6);
    check("illegal_publish_seen", exp_q.size(), 32'd0);

    // Multi-hot strobe mid-acquisition of d0 -> E must not advance any counter
    bus_base = bus_cnt;
    scan({7'h49, 7'h5B, 7'h7C, 7'h79}, 2);
    drive(7'h79, 4'b0011);
    idle(5);
    check("bus_err_count", bus_cnt - bus_base, 32'd1);
    check("dout_after_bus_err", {12'h0, dout, dig_err}, {12'h0, 16'h02BF, 4'b1000});
    exp_q.push_back({16'h02BE, 4'b1000});
    scan({7'h49, 7'h5B, 7'h7C, 7'h79}, 1);
    idle(6);
    check("post_bus_err_publish_seen", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a scan
    drive(7'h3F, 4'b0001);
    drive(7'h3F, 4'b0010);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_dout", {16'h0, dout}, 32'h0);
    check("async_reset_dig_err", {28'h0, dig_err}, 32'h0);
    check("async_reset_dout_valid", {31'h0, dout_valid}, 32'h0);
    check("async_reset_bus_err", {31'h0, bus_err}, 32'h0);
    dig_en = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    exp_q.push_back({16'h0000, 4'b0000});
    scan({7'h3F, 7'h3F, 7'h3F, 7'h3F}, 3);
    idle(6);
    check("zero_publish_seen", exp_q.size(), 32'd0);
    check("bus_err_total", bus_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule
